// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests 4-word cache lines and issues one 16-bit word per handshake.
// Optional macro FETCH_PREFETCH_EN adds a second line buffer that prefetches the next sequential line.
module fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  output logic        lineReq,
  output logic [15:0] lineAddr,
  input  logic        lineValid,
  input  logic [63:0] lineData,
  output logic [15:0] instr,
  output logic [15:0] instrPC,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [15:0] redirectPC
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  sel_q, sel_d;
  logic [63:0] buf_q, buf_d;
  logic        line_req_q, line_req_d;
  logic [15:0] line_addr_q, line_addr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        line_take_s;
  logic        hs_s;
  logic [15:0] pc_inc_s;
`ifdef FETCH_PREFETCH_EN
  logic [63:0] pf_q, pf_d;
  logic        pf_valid_q, pf_valid_d;
`endif

  function automatic logic [15:0] word_of(input logic [63:0] line, input logic [1:0] k);
    case (k)
      2'd0:    word_of = line[15:0];
      2'd1:    word_of = line[31:16];
      2'd2:    word_of = line[47:32];
      2'd3:    word_of = line[63:48];
      default: word_of = 16'h0000;
    endcase
  endfunction

  // A returned line is only meaningful while our own request is still raised.
  assign line_take_s = lineValid & line_req_q;
  assign hs_s        = instr_valid_q & instrReady;
  assign pc_inc_s    = pc_q + 16'd1;

  // Next-state, buffer and registered-output computation.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    sel_d         = sel_q;
    buf_d         = buf_q;
    line_req_d    = line_req_q;
    line_addr_d   = line_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
`ifdef FETCH_PREFETCH_EN
    pf_d          = pf_q;
    pf_valid_d    = pf_valid_q;
`endif
    if (redirect) begin
      state_d       = FETCH;
      pc_d          = redirectPC;
      sel_d         = 2'd0;
      buf_d         = 64'd0;
      line_req_d    = 1'b0;
      line_addr_d   = {redirectPC[15:2], 2'b00};
      instr_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_d          = 64'd0;
      pf_valid_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (line_take_s) begin
            state_d       = ISSUE;
            buf_d         = lineData;
            sel_d         = pc_q[1:0];
            instr_valid_d = 1'b1;
            instr_d       = word_of(lineData, pc_q[1:0]);
            instr_pc_d    = pc_q;
`ifdef FETCH_PREFETCH_EN
            line_req_d    = 1'b1;
            line_addr_d   = {pc_q[15:2] + 14'd1, 2'b00};
`else
            line_req_d    = 1'b0;
`endif
          end else begin
            line_req_d  = 1'b1;
            line_addr_d = {pc_q[15:2], 2'b00};
          end
        end
        ISSUE: begin
`ifdef FETCH_PREFETCH_EN
          if (line_take_s) begin
            pf_d       = lineData;
            pf_valid_d = 1'b1;
            line_req_d = 1'b0;
          end else begin
            pf_d       = pf_q;
            pf_valid_d = pf_valid_q;
          end
`endif
          if (hs_s) begin
            pc_d       = pc_inc_s;
            instr_pc_d = pc_inc_s;
            if (sel_q != 2'd3) begin
              sel_d   = sel_q + 2'd1;
              instr_d = word_of(buf_q, sel_q + 2'd1);
            end else begin
              // Last word of the line: either promote the prefetched line or go fetch.
              state_d       = FETCH;
              sel_d         = 2'd0;
              instr_valid_d = 1'b0;
              line_req_d    = 1'b1;
              line_addr_d   = {pc_inc_s[15:2], 2'b00};
`ifdef FETCH_PREFETCH_EN
              if (pf_valid_q || line_take_s) begin
                state_d       = ISSUE;
                buf_d         = pf_valid_q ? pf_q : lineData;
                instr_d       = word_of(pf_valid_q ? pf_q : lineData, 2'd0);
                instr_valid_d = 1'b1;
                pf_valid_d    = 1'b0;
                line_addr_d   = {pc_inc_s[15:2] + 14'd1, 2'b00};
              end else begin
                pf_valid_d = pf_valid_q;
              end
`endif
            end
          end else begin
            pc_d = pc_q;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= 16'h0000;
      sel_q         <= 2'd0;
      buf_q         <= 64'd0;
      line_req_q    <= 1'b0;
      line_addr_q   <= 16'h0000;
      instr_valid_q <= 1'b0;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
`ifdef FETCH_PREFETCH_EN
      pf_q          <= 64'd0;
      pf_valid_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sel_q         <= sel_d;
      buf_q         <= buf_d;
      line_req_q    <= line_req_d;
      line_addr_q   <= line_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
`ifdef FETCH_PREFETCH_EN
      pf_q          <= pf_d;
      pf_valid_q    <= pf_valid_d;
`endif
    end
  end

  assign lineReq    = line_req_q;
  assign lineAddr   = line_addr_q;
  assign instrValid = instr_valid_q;
  assign instr      = instr_q;
  assign instrPC    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; the line at word address A holds words A+1..A+4,
// so every issued instruction must equal its instrPC + 1.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        lineReq;
  logic [15:0] lineAddr;
  logic        lineValid;
  logic [63:0] lineData;
  logic [15:0] instr;
  logic [15:0] instrPC;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [15:0] redirectPC;

  logic        resp_lv;
  logic [63:0] resp_data;
  logic        man_lv;
  logic [63:0] man_data;
  logic        cache_en;
  int          lat;
  int          n_checks;
  int          n_pass;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .lineReq    (lineReq),
    .lineAddr   (lineAddr),
    .lineValid  (lineValid),
    .lineData   (lineData),
    .instr      (instr),
    .instrPC    (instrPC),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .redirect   (redirect),
    .redirectPC (redirectPC)
  );

  assign lineValid = resp_lv | man_lv;
  assign lineData  = man_lv ? man_data : resp_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] line_of(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:2], 2'b00};
    line_of = {b + 16'd4, b + 16'd3, b + 16'd2, b + 16'd1};
  endfunction

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (instrValid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, {47'd0, instrValid}, 48'd1);
  endtask

  // Cache model: serves a raised request after lat cycles, driving just after the rising edge.
  initial begin
    int cnt;
    cnt = 0;
    resp_lv = 1'b0;
    resp_data = 64'd0;
    forever begin
      @(posedge clk);
      #2;
      resp_lv = 1'b0;
      if (cache_en && lineReq && !rst) begin
        if (cnt >= lat - 1) begin
          resp_lv = 1'b1;
          resp_data = line_of(lineAddr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    logic [15:0] p;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    cache_en = 1'b0;
    lat = 1;
    man_lv = 1'b0;
    man_data = 64'd0;
    instrReady = 1'b0;
    redirect = 1'b0;
    redirectPC = 16'h0000;

    repeat (3) @(negedge clk);
    check_eq("rst_lineReq", {47'd0, lineReq}, 48'd0);
    check_eq("rst_lineAddr", {32'd0, lineAddr}, 48'd0);
    check_eq("rst_instrValid", {47'd0, instrValid}, 48'd0);
    check_eq("rst_instr", {32'd0, instr}, 48'd0);
    check_eq("rst_instrPC", {32'd0, instrPC}, 48'd0);

    // Reset release and a full line at one word per cycle.
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("first_req", {31'd0, lineReq, lineAddr}, {31'd0, 1'b1, 16'h0000});
    cache_en = 1'b1;
    instrReady = 1'b1;
    wait_valid("line0");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      p = 16'(i);
      check_eq("line0_word", {15'd0, instrValid, instrPC, instr}, {15'd0, 1'b1, p, p + 16'd1});
      cache_en = 1'b0;
    end
    @(negedge clk);
    check_eq("line0_refetch", {30'd0, instrValid, lineReq, lineAddr}, {30'd0, 1'b0, 1'b1, 16'h0004});

    // Stall on the second word of line 4.
    instrReady = 1'b0;
    man_lv = 1'b1;
    man_data = line_of(16'h0004);
    @(negedge clk);
    man_lv = 1'b0;
    check_eq("line4_word0", {15'd0, instrValid, instrPC, instr}, {15'd0, 1'b1, 16'h0004, 16'h0005});
    instrReady = 1'b1;
    @(negedge clk);
    instrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_hold", {14'd0, instrValid, lineReq, instrPC, instr},
               {14'd0, 1'b1, 1'b0, 16'h0005, 16'h0006});
    end

    // Unaligned redirect during issue.
    redirect = 1'b1;
    redirectPC = 16'h0102;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("redir_bubble", {46'd0, instrValid, lineReq}, 48'd0);
    @(negedge clk);
    check_eq("redir_req", {31'd0, lineReq, lineAddr}, {31'd0, 1'b1, 16'h0100});
    cache_en = 1'b1;
    instrReady = 1'b1;
    wait_valid("redir");
    cache_en = 1'b0;
    check_eq("redir_w2", {15'd0, instrValid, instrPC, instr}, {15'd0, 1'b1, 16'h0102, 16'h0103});
    @(negedge clk);
    check_eq("redir_w3", {15'd0, instrValid, instrPC, instr}, {15'd0, 1'b1, 16'h0103, 16'h0104});
    @(negedge clk);
    check_eq("redir_end", {30'd0, instrValid, lineReq, lineAddr}, {30'd0, 1'b0, 1'b1, 16'h0104});

    // Redirect coincident with lineValid, then a stale line while no request is raised.
    redirect = 1'b1;
    redirectPC = 16'h0200;
    man_lv = 1'b1;
    man_data = line_of(16'h0104);
    @(negedge clk);
    redirect = 1'b0;
    check_eq("coinc_drop", {46'd0, instrValid, lineReq}, 48'd0);
    @(negedge clk);
    man_lv = 1'b0;
    check_eq("coinc_req", {30'd0, instrValid, lineReq, lineAddr}, {30'd0, 1'b0, 1'b1, 16'h0200});
    @(negedge clk);
    check_eq("stale_ignored", {47'd0, instrValid}, 48'd0);

    // Wrap at the top of the address space.
    redirect = 1'b1;
    redirectPC = 16'hFFFC;
    @(negedge clk);
    redirect = 1'b0;
    cache_en = 1'b1;
    wait_valid("wrap");
    cache_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      p = 16'hFFFC + 16'(i);
      check_eq("wrap_word", {15'd0, instrValid, instrPC, instr}, {15'd0, 1'b1, p, p + 16'd1});
    end
    @(negedge clk);
    check_eq("wrap_req", {30'd0, instrValid, lineReq, lineAddr}, {30'd0, 1'b0, 1'b1, 16'h0000});

    // Reset mid-request; a line pending at release must be ignored.
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst", {14'd0, lineReq, instrValid, instrPC, instr}, 48'd0);
    check_eq("midrst_addr", {32'd0, lineAddr}, 48'd0);
    man_lv = 1'b1;
    man_data = line_of(16'h0000);
    rst = 1'b0;
    @(negedge clk);
    man_lv = 1'b0;
    check_eq("midrst_ignore", {30'd0, instrValid, lineReq, lineAddr}, {30'd0, 1'b0, 1'b1, 16'h0000});

`ifdef FETCH_PREFETCH_EN
    // Prefetch keeps the stream gapless across line boundaries.
    redirect = 1'b1;
    redirectPC = 16'h0010;
    @(negedge clk);
    redirect = 1'b0;
    lat = 2;
    cache_en = 1'b1;
    instrReady = 1'b1;
    wait_valid("pf");
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      p = 16'h0010 + 16'(i);
      check_eq("pf_word", {15'd0, instrValid, instrPC, instr}, {15'd0, 1'b1, p, p + 16'd1});
    end
    cache_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
